// File: rtl/uart_cmd_controller.sv
// UART command frame controller: parses SOF/OP/A/B/CHK requests, drives ALU operands
// on valid frames, and returns a SOF/result/status response frame.
module uart_cmd_controller #(
  parameter int unsigned     DBIT          = 8,
  parameter int unsigned     NB_OP         = 6,
  parameter logic [DBIT-1:0] SOF_RX        = 8'hA5,
  parameter logic [DBIT-1:0] SOF_TX        = 8'h5A,
  parameter int unsigned     TIMEOUT_TICKS = 1600,
  parameter int unsigned     NB_TIMEOUT    = 11
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_tick,
  input  logic             i_rx_done_tick,
  input  logic [DBIT-1:0]  i_rx_data,
  input  logic             i_tx_done_tick,
  input  logic [DBIT-1:0]  i_alu_result,
  output logic [DBIT-1:0]  o_data_a,
  output logic [DBIT-1:0]  o_data_b,
  output logic [NB_OP-1:0] o_operation,
  output logic             o_tx_start,
  output logic [DBIT-1:0]  o_tx_data,
  output logic             o_busy,
  output logic             o_frame_err
);

  typedef enum logic [3:0] {
    IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, TX_SOF, TX_RES, TX_STAT
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] TO_LAST = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

  state_t              r_state, w_next;
  logic                r_wait;
  logic                r_to_err;
  logic [DBIT-1:0]     r_op, r_a, r_b;
  logic [DBIT-1:0]     r_status, r_result, r_tx_data;
  logic [DBIT-1:0]     r_data_a, r_data_b;
  logic [NB_OP-1:0]    r_operation;
  logic [NB_TIMEOUT-1:0] r_cnt;

  logic            w_in_get, w_is_tx, w_timeout, w_tx_done;
  logic [DBIT-1:0] w_status;

  assign w_in_get  = r_state inside {GET_OP, GET_A, GET_B, GET_CHK};
  assign w_is_tx   = r_state inside {TX_SOF, TX_RES, TX_STAT};
  // An accepted byte wins over a coincident timeout tick.
  assign w_timeout = w_in_get && i_tick && !i_rx_done_tick && (r_cnt == TO_LAST);
  assign w_tx_done = w_is_tx && r_wait && i_tx_done_tick;

  always_comb begin
    w_status = '0;
    if (i_rx_data != (r_op ^ r_a ^ r_b))
      w_status = DBIT'(1);
    else if ((r_op >> NB_OP) != '0)
      w_status = DBIT'(2);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_rx_done_tick && i_rx_data == SOF_RX) w_next = GET_OP;
      GET_OP:  if (i_rx_done_tick) w_next = GET_A;   else if (w_timeout) w_next = IDLE;
      GET_A:   if (i_rx_done_tick) w_next = GET_B;   else if (w_timeout) w_next = IDLE;
      GET_B:   if (i_rx_done_tick) w_next = GET_CHK; else if (w_timeout) w_next = IDLE;
      GET_CHK: if (i_rx_done_tick) w_next = EXEC;    else if (w_timeout) w_next = IDLE;
      EXEC:    w_next = TX_SOF;
      TX_SOF:  if (w_tx_done) w_next = TX_RES;
      TX_RES:  if (w_tx_done) w_next = TX_STAT;
      TX_STAT: if (w_tx_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_wait      <= 1'b0;
      r_to_err    <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_status    <= '0;
      r_result    <= '0;
      r_tx_data   <= '0;
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_operation <= '0;
      r_cnt       <= '0;
    end else begin
      r_state  <= w_next;
      r_to_err <= w_timeout;
      // WAIT phase starts the cycle after entering a TX state.
      r_wait   <= w_is_tx && (w_next == r_state);

      if ((r_state == IDLE && w_next == GET_OP) || (w_in_get && i_rx_done_tick))
        r_cnt <= '0;
      else if (w_in_get && i_tick)
        r_cnt <= r_cnt + 1'b1;

      case (r_state)
        GET_OP: if (i_rx_done_tick) r_op <= i_rx_data;
        GET_A:  if (i_rx_done_tick) r_a  <= i_rx_data;
        GET_B:  if (i_rx_done_tick) r_b  <= i_rx_data;
        GET_CHK: if (i_rx_done_tick) begin
          r_status <= w_status;
          if (w_status == '0) begin
            r_operation <= r_op[NB_OP-1:0];
            r_data_a    <= r_a;
            r_data_b    <= r_b;
          end
        end
        EXEC: begin
          r_result  <= (r_status == '0) ? i_alu_result : '0;
          r_tx_data <= SOF_TX;
        end
        TX_SOF: if (w_tx_done) r_tx_data <= r_result;
        TX_RES: if (w_tx_done) r_tx_data <= r_status;
        default: ;
      endcase
    end
  end

  assign o_data_a    = r_data_a;
  assign o_data_b    = r_data_b;
  assign o_operation = r_operation;
  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = w_is_tx && !r_wait;
  assign o_busy      = (r_state != IDLE);
  assign o_frame_err = ((r_state == EXEC) && (r_status != '0)) || r_to_err;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Directed + randomized bench for uart_cmd_controller with a frame-level reference model.
module tb_uart_cmd_controller;

  logic       clk = 1'b0;
  logic       rst, tick, rx_done, tx_done;
  logic [7:0] rx_data, alu_result, data_a, data_b, tx_data;
  logic [5:0] operation;
  logic       tx_start, busy, frame_err;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;
  int errs     = 0;
  bit resp_en  = 1'b1;
  logic [7:0] txq[$];

  // Model ALU state (loaded only by valid frames)
  logic [7:0] m_op = '0, m_a = '0, m_b = '0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    return (a + b) ^ {2'b00, op};
  endfunction

  assign alu_result = alu_fn(operation, data_a, data_b);

  uart_cmd_controller #(.DBIT(8), .NB_OP(6), .TIMEOUT_TICKS(1600), .NB_TIMEOUT(11)) dut (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_rx_done_tick(rx_done), .i_rx_data(rx_data),
    .i_tx_done_tick(tx_done), .i_alu_result(alu_result), .o_data_a(data_a), .o_data_b(data_b),
    .o_operation(operation), .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy),
    .o_frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start)  starts++;
    if (frame_err) errs++;
  end

  // Transmitter stand-in: completes each byte 10 cycles after its start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && resp_en) begin
        automatic logic [7:0] b = tx_data;
        txq.push_back(b);
        repeat (10) @(posedge clk);
        #1;
        if (resp_en) begin
          check("tx_stable", tx_data, b);
          tx_done = 1'b1;
          @(posedge clk); #1;
          tx_done = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic with_tick);
    @(posedge clk); #1;
    rx_data = b; rx_done = 1'b1; tick = with_tick;
    @(posedge clk); #1;
    rx_done = 1'b0; tick = 1'b0;
  endtask

  task automatic wait_txq(input int n);
    for (int i = 0; i < 300 && txq.size() < n; i++) @(negedge clk);
    check("tx_count", txq.size(), n);
  endtask

  // Called right after the CHK byte was accepted; checks EXEC/latency and the response.
  task automatic expect_resp(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] chk, input bit inject);
    logic [7:0] st, res;
    int e0;
    e0 = errs;
    txq.delete();
    if (chk != (op ^ a ^ b))      st = 8'h01;
    else if ((op >> 6) != 0)      st = 8'h02;
    else                          st = 8'h00;
    if (st == 8'h00) begin
      m_op = op & 8'h3F; m_a = a; m_b = b;
      res = alu_fn(op[5:0], a, b);
    end else res = 8'h00;
    @(negedge clk);
    check("exec_start", tx_start, 1'b0);
    check("exec_busy", busy, 1'b1);
    check("exec_err", frame_err, st != 0);
    check("alu_op", operation, m_op);
    check("alu_a", data_a, m_a);
    check("alu_b", data_b, m_b);
    @(negedge clk);
    check("start_lat", tx_start, 1'b1);
    if (inject) begin
      wait_txq(2);
      send_byte(8'hA5, 1'b0);
    end
    wait_txq(3);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("idle_after", busy, 1'b0);
    check("tx_sof", txq[0], 8'h5A);
    check("tx_res", txq[1], res);
    check("tx_stat", txq[2], st);
    check("err_cnt", errs - e0, (st != 0) ? 1 : 0);
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] chk, input bit inject);
    send_byte(8'hA5, 1'b0);
    send_byte(op, 1'b0);
    send_byte(a, 1'b0);
    send_byte(b, 1'b0);
    send_byte(chk, 1'b0);
    expect_resp(op, a, b, chk, inject);
  endtask

  initial begin
    int s0, e0;
    logic [7:0] op, a, b, chk, g;
    rst = 1'b1; tick = 0; rx_done = 0; tx_done = 0; rx_data = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_start", tx_start, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_txdata", tx_data, 8'h00);
    check("rst_alu", {operation, data_a, data_b}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_frame(8'h20, 8'h05, 8'h03, 8'h26, 1'b0);   // valid
    run_frame(8'h20, 8'h05, 8'h03, 8'h27, 1'b0);   // bad checksum
    run_frame(8'hE0, 8'h05, 8'h03, 8'hE6, 1'b0);   // bad opcode high bits

    // Leading garbage, then extra byte during the result byte
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h5A, 1'b0);
    check("garbage_idle", busy, 1'b0);
    run_frame(8'h11, 8'h40, 8'h02, 8'h53, 1'b1);

    // Timeout after OP byte
    s0 = starts; e0 = errs;
    send_byte(8'hA5, 1'b0); send_byte(8'h20, 1'b0);
    tick = 1'b1;
    repeat (1599) @(posedge clk);
    #1 tick = 1'b0;
    @(negedge clk);
    check("to_pre_busy", busy, 1'b1);
    check("to_pre_err", errs - e0, 0);
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(negedge clk);
    check("to_busy", busy, 1'b0);
    check("to_err", frame_err, 1'b1);
    @(negedge clk);
    check("to_err_pulse", frame_err, 1'b0);
    repeat (5) @(negedge clk);
    check("to_nostart", starts - s0, 0);
    run_frame(8'h20, 8'h05, 8'h03, 8'h26, 1'b0);

    // Byte coincident with the final timeout tick is accepted
    send_byte(8'hA5, 1'b0); send_byte(8'h07, 1'b0);
    tick = 1'b1;
    repeat (1599) @(posedge clk);
    #1 tick = 1'b0;
    send_byte(8'h10, 1'b1);
    check("race_busy", busy, 1'b1);
    send_byte(8'h20, 1'b0);
    send_byte(8'h07 ^ 8'h10 ^ 8'h20, 1'b0);
    expect_resp(8'h07, 8'h10, 8'h20, 8'h07 ^ 8'h10 ^ 8'h20, 1'b0);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      op = 8'($urandom);
      if ($urandom_range(0, 2) != 0) op = op & 8'h3F;
      a = 8'($urandom); b = 8'($urandom);
      chk = op ^ a ^ b;
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'(1 << $urandom_range(0, 7));
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 1'b0);
      end
      run_frame(op, a, b, chk, 1'b0);
    end

    // Reset during TX_RES wait
    send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h09, 1'b0);
    send_byte(8'h04, 1'b0); send_byte(8'h03 ^ 8'h09 ^ 8'h04, 1'b0);
    txq.delete();
    wait_txq(2);
    repeat (3) @(posedge clk);
    #2 resp_en = 1'b0; rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_start", tx_start, 1'b0);
    check("mid_rst_txdata", tx_data, 8'h00);
    check("mid_rst_alu", {operation, data_a, data_b}, 0);
    m_op = '0; m_a = '0; m_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    s0 = starts;
    repeat (30) @(negedge clk);
    check("post_rst_nostart", starts - s0, 0);
    check("post_rst_busy", busy, 1'b0);
    resp_en = 1'b1;
    run_frame(8'h2A, 8'hF0, 8'h0F, 8'h2A ^ 8'hF0 ^ 8'h0F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_controller.md
UART_CMD_CONTROLLER -- requirements
Module: uart_cmd_controller

Interface
REQ-001 SHALL have parameter DBIT, default 8, data/byte width.
REQ-002 SHALL have parameter NB_OP, default 6, ALU operation width.
REQ-003 SHALL have parameter SOF_RX, default 8'hA5, request start-of-frame byte.
REQ-004 SHALL have parameter SOF_TX, default 8'h5A, response start-of-frame byte.
REQ-005 SHALL have parameter TIMEOUT_TICKS, default 1600, inter-byte timeout in baud ticks (10 byte times at 16 ticks/bit).
REQ-006 SHALL have parameter NB_TIMEOUT, default 11, timeout counter width.
REQ-007 SHALL have ports, one clock, reset asynchronous active-high:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_tick  in  1  baud-rate tick (16x oversample strobe)
i_rx_done_tick  in  1  one-cycle strobe, received byte valid
i_rx_data  in  DBIT  received byte
i_tx_done_tick  in  1  one-cycle strobe, transmitter finished byte
i_alu_result  in  DBIT  combinational ALU result
o_data_a  out  DBIT  ALU operand A
o_data_b  out  DBIT  ALU operand B
o_operation  out  NB_OP  ALU operation code
o_tx_start  out  1  one-cycle transmit request
o_tx_data  out  DBIT  byte to transmit, stable from o_tx_start until i_tx_done_tick
o_busy  out  1  high whenever state is not IDLE
o_frame_err  out  1  one-cycle pulse on timeout or checksum/opcode error

Function
REQ-008 SHALL implement states IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, TX_SOF, TX_RES, TX_STAT; TX_* each have a START sub-cycle and a WAIT phase.
REQ-009 Request frame: SOF_RX, OP, A, B, CHK; CHK valid iff CHK == OP ^ A ^ B.
REQ-010 IDLE: byte == SOF_RX -> GET_OP; any other byte ignored, no error.
REQ-011 GET_OP/GET_A/GET_B/GET_CHK: each i_rx_done_tick stores byte into shadow register and advances one state.
REQ-012 Shadow registers SHALL NOT drive ALU outputs; o_data_a/o_data_b/o_operation load only on a valid frame.
REQ-013 In GET_CHK on CHK byte: status = 0x01 if checksum mismatch; else 0x02 if OP[DBIT-1:NB_OP] != 0; else 0x00 and ALU outputs load OP[NB_OP-1:0], A, B same edge; state -> EXEC.
REQ-014 Nonzero status SHALL pulse o_frame_err in EXEC cycle and leave ALU outputs unchanged.
REQ-015 EXEC lasts exactly 1 cycle; i_alu_result captured at end of EXEC if status 0x00, else result byte = 0x00.
REQ-016 Response frame: SOF_TX, result, status, in that order.
REQ-017 o_tx_start SHALL pulse for exactly 1 cycle on entry to each TX_* state; first pulse is the cycle after EXEC (CHK byte strobe -> o_tx_start latency 2 cycles).
REQ-018 Controller advances to next TX_* state or IDLE only on i_tx_done_tick; no timeout applies in TX_* states.
REQ-019 i_rx_done_tick during EXEC or TX_* states SHALL be ignored (no buffering).
REQ-020 Timeout counter clears on entry to GET_OP and on each accepted byte; increments on i_tick in GET_* states; at TIMEOUT_TICKS -> IDLE, pulse o_frame_err, no response, ALU outputs unchanged.
REQ-021 i_rx_done_tick and timeout in same cycle: byte accepted, timeout discarded.
REQ-022 o_busy combinationally equals (state != IDLE).
REQ-023 Spurious i_tx_done_tick outside WAIT phases SHALL be ignored.

Reset
REQ-024 On i_reset high, immediately: state IDLE; o_data_a, o_data_b, o_operation, o_tx_data, shadow registers, timeout counter = 0; o_tx_start, o_busy, o_frame_err = 0.
REQ-025 Reset asserted mid-frame or mid-transmission SHALL abort with no further o_tx_start after release.

Verification
REQ-026 Rx A5 20 05 03 26, tx_done returned 10 cycles after each start -> o_operation=0x20, A=0x05, B=0x03; transmitted 5A, <ALU result>, 00; o_frame_err never high.
REQ-027 Rx A5 20 05 03 27 -> ALU outputs unchanged from prior values; o_frame_err 1-cycle pulse; transmitted 5A 00 01.
REQ-028 Rx A5 E0 05 03 E6 -> status 0x02; transmitted 5A 00 02; o_operation unchanged.
REQ-029 Rx A5 20 then 1600 i_tick with no byte -> IDLE, o_frame_err pulse, o_tx_start never asserted; following full valid frame processed normally.
REQ-030 Rx 00 FF 5A before A5 20 05 03 26 -> leading bytes ignored, single correct response; extra byte received during TX_RES ignored.
REQ-031 Assert i_reset during TX_RES WAIT -> all outputs 0 within same cycle, o_busy 0, no o_tx_start after release until new frame.
